// File: rtl/melody_sequencer.sv
// Plays a fixed 16-entry note table as a one-hot piezo tone vector, with gaps and repeats.
// Optional MELODY_SNOOZE_EN adds a snooze input that silences and later restarts the melody.
module melody_sequencer #(
    parameter int UNIT_CYCLES = 125000,
    parameter int GAP_CYCLES  = 12500,
    parameter int REPEAT      = 3
`ifdef MELODY_SNOOZE_EN
    ,
    parameter int SNOOZE_CYCLES = 5000000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
`ifdef MELODY_SNOOZE_EN
    input  logic        snooze,
`endif
    output logic [12:0] playSound,
    output logic        busy,
    output logic        done
);

    localparam int CYC_W  = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    localparam logic [CYC_W-1:0] UNIT_LAST = CYC_W'(UNIT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [PASS_W:0]  REPEAT_V  = (PASS_W + 1)'(REPEAT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
`ifdef MELODY_SNOOZE_EN
    localparam logic [2:0] S_SNOOZE = 3'd4;
    localparam int SNZ_W = (SNOOZE_CYCLES > 1) ? $clog2(SNOOZE_CYCLES) : 1;
    localparam logic [SNZ_W-1:0] SNZ_LAST =
        SNZ_W'((SNOOZE_CYCLES > 0) ? SNOOZE_CYCLES - 1 : 0);
`endif

    // Entry format {end, code[3:0], len[2:0]}; len encodes units-1.
    function automatic logic [7:0] table_entry(input logic [3:0] i);
        case (i)
            4'd0:    table_entry = {1'b0, 4'd8,  3'd1};
            4'd1:    table_entry = {1'b0, 4'd8,  3'd1};
            4'd2:    table_entry = {1'b0, 4'd10, 3'd1};
            4'd3:    table_entry = {1'b0, 4'd10, 3'd1};
            4'd4:    table_entry = {1'b0, 4'd12, 3'd1};
            4'd5:    table_entry = {1'b0, 4'd12, 3'd1};
            4'd6:    table_entry = {1'b0, 4'd10, 3'd3};
            4'd7:    table_entry = {1'b0, 4'd0,  3'd1};
            4'd8:    table_entry = {1'b0, 4'd9,  3'd1};
            4'd9:    table_entry = {1'b0, 4'd9,  3'd1};
            4'd10:   table_entry = {1'b0, 4'd7,  3'd1};
            4'd11:   table_entry = {1'b0, 4'd7,  3'd1};
            4'd12:   table_entry = {1'b0, 4'd5,  3'd3};
            default: table_entry = {1'b1, 4'd0,  3'd0};
        endcase
    endfunction

    // Codes 0 and 13..15 are rests: bit 0 is masked, bits past 12 shift out.
    function automatic logic [12:0] tone(input logic [3:0] code);
        tone = (13'd1 << code) & 13'h1FFE;
    endfunction

    logic [2:0]        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic              wrap_q, wrap_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [2:0]        unit_q, unit_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              start_q, start_d;
    logic [12:0]       play_q, play_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef MELODY_SNOOZE_EN
    logic [SNZ_W-1:0]  snz_q, snz_d;
`endif

    logic [7:0]        entry;
    logic              is_end;
    logic [PASS_W:0]   pass_inc;
    logic              last_pass;

    always_comb begin
        entry     = table_entry(idx_q);
        is_end    = entry[7] | wrap_q;
        pass_inc  = {1'b0, pass_q} + (PASS_W + 1)'(1);
        last_pass = (REPEAT != 0) && (pass_inc >= REPEAT_V);

        state_d = state_q;
        idx_d   = idx_q;
        wrap_d  = wrap_q;
        pass_d  = pass_q;
        unit_d  = unit_q;
        cyc_d   = cyc_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        start_d = start & ~stop & (state_q == S_IDLE);
`ifdef MELODY_SNOOZE_EN
        snz_d   = snz_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start_q && !stop) begin
                    state_d = S_LOAD;
                    idx_d   = 4'd0;
                    wrap_d  = 1'b0;
                    pass_d  = '0;
                end
            end
            S_LOAD: begin
                if (is_end) begin
                    wrap_d = 1'b0;
                    idx_d  = 4'd0;
                    if (last_pass) begin
                        state_d = S_IDLE;
                        pass_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        pass_d = pass_inc[PASS_W-1:0];
                    end
                end else begin
                    state_d = S_PLAY;
                    unit_d  = entry[2:0];
                    cyc_d   = UNIT_LAST;
                end
            end
            S_PLAY: begin
                if (cyc_q != '0) begin
                    cyc_d = cyc_q - CYC_W'(1);
                end else if (unit_q != 3'd0) begin
                    unit_d = unit_q - 3'd1;
                    cyc_d  = UNIT_LAST;
                end else begin
                    // Stepping past entry 15 wraps and is taken as end of table.
                    idx_d  = idx_q + 4'd1;
                    wrap_d = (idx_q == 4'd15);
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_LAST;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else begin
                    state_d = S_LOAD;
                end
            end
`ifdef MELODY_SNOOZE_EN
            S_SNOOZE: begin
                if (snz_q != '0) begin
                    snz_d = snz_q - SNZ_W'(1);
                end else begin
                    state_d = S_LOAD;
                    idx_d   = 4'd0;
                    wrap_d  = 1'b0;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef MELODY_SNOOZE_EN
        if (snooze && state_q != S_IDLE) begin
            state_d = S_SNOOZE;
            snz_d   = SNZ_LAST;
            done_d  = 1'b0;
        end
`endif

        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            idx_d   = 4'd0;
            wrap_d  = 1'b0;
            pass_d  = '0;
            unit_d  = 3'd0;
            cyc_d   = '0;
            gap_d   = '0;
            done_d  = 1'b0;
`ifdef MELODY_SNOOZE_EN
            snz_d   = '0;
`endif
        end

        busy_d = (state_d != S_IDLE);
        play_d = 13'd0;
        if (state_d == S_PLAY) begin
            play_d = (state_q == S_LOAD) ? tone(entry[6:3]) : play_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            wrap_q  <= 1'b0;
            pass_q  <= '0;
            unit_q  <= 3'd0;
            cyc_q   <= '0;
            gap_q   <= '0;
            start_q <= 1'b0;
            play_q  <= 13'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MELODY_SNOOZE_EN
            snz_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            pass_q  <= pass_d;
            unit_q  <= unit_d;
            cyc_q   <= cyc_d;
            gap_q   <= gap_d;
            start_q <= start_d;
            play_q  <= play_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MELODY_SNOOZE_EN
            snz_q   <= snz_d;
`endif
        end
    end

    assign playSound = play_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: one DUT with REPEAT=1, one with REPEAT=2.
// UNIT_CYCLES=4, GAP_CYCLES=2 throughout.
module tb_melody_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
`ifdef MELODY_SNOOZE_EN
    logic        snooze = 1'b0;
`endif
    logic [12:0] ps1, ps2;
    logic        busy1, busy2, done1, done2;

    int checks = 0;
    int errors = 0;

    logic [12:0] trace[$];
    int codes[13] = '{8, 8, 10, 10, 12, 12, 10, 0, 9, 9, 7, 7, 5};
    int lens[13]  = '{1, 1, 1, 1, 1, 1, 3, 1, 1, 1, 1, 1, 3};

    melody_sequencer #(
        .UNIT_CYCLES(4), .GAP_CYCLES(2), .REPEAT(1)
`ifdef MELODY_SNOOZE_EN
        , .SNOOZE_CYCLES(20)
`endif
    ) u1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
`ifdef MELODY_SNOOZE_EN
        .snooze(snooze),
`endif
        .playSound(ps1), .busy(busy1), .done(done1)
    );

    melody_sequencer #(
        .UNIT_CYCLES(4), .GAP_CYCLES(2), .REPEAT(2)
`ifdef MELODY_SNOOZE_EN
        , .SNOOZE_CYCLES(20)
`endif
    ) u2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
`ifdef MELODY_SNOOZE_EN
        .snooze(snooze),
`endif
        .playSound(ps2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (!$onehot0(ps1) || ps1[0] || !$onehot0(ps2) || ps2[0]) begin
                errors++;
                $display("FAIL onehot ps1=%h ps2=%h required onehot0 with bit0=0",
                         ps1, ps2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (ps1 !== 13'h0 || busy1 !== 1'b0 || done1 !== 1'b0 ||
            ps2 !== 13'h0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL reset ps1=%h b1=%b d1=%b ps2=%h b2=%b d2=%b required all 0",
                     ps1, busy1, done1, ps2, busy2, done2);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_pass();
        pulse_start();
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL latency_busy_early busy=%b required 0", busy1);
        end
        tick();
        checks++;
        if (busy1 !== 1'b1 || ps1 !== 13'h0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL load_cycle busy=%b play=%h done=%b required 1 0000 0",
                     busy1, ps1, done1);
        end
        for (int t = 0; t < trace.size(); t++) begin
            tick();
            checks++;
            if (ps1 !== trace[t] || busy1 !== 1'b1 || done1 !== 1'b0) begin
                errors++;
                $display("FAIL single_pass t=%0d play=%h busy=%b done=%b required play=%h busy=1 done=0",
                         t, ps1, busy1, done1, trace[t]);
            end
        end
        tick();
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || ps1 !== 13'h0) begin
            errors++;
            $display("FAIL done_pulse done=%b busy=%b play=%h required 1 0 0000",
                     done1, busy1, ps1);
        end
        tick();
        checks++;
        if (done1 !== 1'b0) begin
            errors++;
            $display("FAIL done_width done=%b required 0", done1);
        end
        do_stop();
    endtask

    task automatic test_repeat();
        pulse_start();
        tick();
        checks++;
        if (busy2 !== 1'b1) begin
            errors++;
            $display("FAIL repeat_busy busy=%b required 1", busy2);
        end
        for (int p = 0; p < 2; p++) begin
            for (int t = 0; t < trace.size(); t++) begin
                tick();
                checks++;
                if (ps2 !== trace[t] || busy2 !== 1'b1 || done2 !== 1'b0) begin
                    errors++;
                    $display("FAIL repeat p=%0d t=%0d play=%h busy=%b done=%b required play=%h busy=1 done=0",
                             p, t, ps2, busy2, done2, trace[t]);
                end
            end
            if (p == 0) begin
                tick();
                checks++;
                if (ps2 !== 13'h0 || busy2 !== 1'b1 || done2 !== 1'b0) begin
                    errors++;
                    $display("FAIL repeat_reload play=%h busy=%b done=%b required 0000 1 0",
                             ps2, busy2, done2);
                end
            end
        end
        tick();
        checks++;
        if (done2 !== 1'b1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL repeat_done done=%b busy=%b required 1 0", done2, busy2);
        end
        tick();
        checks++;
        if (done2 !== 1'b0) begin
            errors++;
            $display("FAIL repeat_done_width done=%b required 0", done2);
        end
    endtask

    task automatic test_stop();
        pulse_start();
        tick();
        repeat (46) tick();
        checks++;
        if (ps1 !== 13'h1000) begin
            errors++;
            $display("FAIL stop_entry4 play=%h required 1000", ps1);
        end
        do_stop();
        checks++;
        if (ps1 !== 13'h0 || busy1 !== 1'b0 || done1 !== 1'b0 ||
            ps2 !== 13'h0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            errors++;
            $display("FAIL stop_abort ps1=%h b1=%b d1=%b ps2=%h b2=%b d2=%b required all 0",
                     ps1, busy1, done1, ps2, busy2, done2);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done1 !== 1'b0 || busy1 !== 1'b0 || done2 !== 1'b0) begin
                errors++;
                $display("FAIL stop_quiet i=%0d done1=%b busy1=%b done2=%b required 0 0 0",
                         i, done1, busy1, done2);
            end
        end
        pulse_start();
        tick();
        checks++;
        if (busy1 !== 1'b1 || ps1 !== 13'h0) begin
            errors++;
            $display("FAIL restart_load busy=%b play=%h required 1 0000", busy1, ps1);
        end
        tick();
        checks++;
        if (ps1 !== 13'h0100) begin
            errors++;
            $display("FAIL restart_entry0 play=%h required 0100", ps1);
        end
        do_stop();
    endtask

    task automatic test_start_stop_idle();
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy1 !== 1'b0 || busy2 !== 1'b0 || ps1 !== 13'h0) begin
                errors++;
                $display("FAIL start_stop_idle i=%0d busy1=%b busy2=%b play=%h required 0 0 0000",
                         i, busy1, busy2, ps1);
            end
            tick();
        end
    endtask

    task automatic test_start_during_play();
        pulse_start();
        tick();
        repeat (4) tick();
        pulse_start();
        checks++;
        if (ps1 !== 13'h0100 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL restart_ignored play=%h busy=%b required 0100 1", ps1, busy1);
        end
        repeat (4) tick();
        checks++;
        if (ps1 !== 13'h0) begin
            errors++;
            $display("FAIL restart_gap play=%h required 0000", ps1);
        end
        repeat (3) tick();
        checks++;
        if (ps1 !== 13'h0100) begin
            errors++;
            $display("FAIL restart_entry1 play=%h required 0100", ps1);
        end
        repeat (11) tick();
        checks++;
        if (ps1 !== 13'h0400) begin
            errors++;
            $display("FAIL restart_entry2 play=%h required 0400", ps1);
        end
        do_stop();
    endtask

    task automatic test_async_reset();
        pulse_start();
        tick();
        repeat (3) tick();
        checks++;
        if (ps1 !== 13'h0100) begin
            errors++;
            $display("FAIL areset_pre play=%h required 0100", ps1);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ps1 !== 13'h0 || busy1 !== 1'b0 || ps2 !== 13'h0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL areset ps1=%h busy1=%b ps2=%h busy2=%b required all 0",
                     ps1, busy1, ps2, busy2);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy1 !== 1'b0 || ps1 !== 13'h0) begin
            errors++;
            $display("FAIL areset_after busy=%b play=%h required 0 0000", busy1, ps1);
        end
    endtask

`ifdef MELODY_SNOOZE_EN
    task automatic test_snooze();
        pulse_start();
        tick();
        repeat (24) tick();
        checks++;
        if (ps1 !== 13'h0400) begin
            errors++;
            $display("FAIL snooze_entry2 play=%h required 0400", ps1);
        end
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        for (int t = 0; t < 21; t++) begin
            checks++;
            if (ps1 !== 13'h0 || busy1 !== 1'b1) begin
                errors++;
                $display("FAIL snooze_quiet t=%0d play=%h busy=%b required 0000 1",
                         t, ps1, busy1);
            end
            tick();
        end
        checks++;
        if (ps1 !== 13'h0100) begin
            errors++;
            $display("FAIL snooze_resume play=%h required 0100", ps1);
        end
        repeat (158) tick();
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL snooze_pre_done done=%b busy=%b required 0 1", done1, busy1);
        end
        tick();
        checks++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL snooze_done done=%b busy=%b required 1 0", done1, busy1);
        end
        do_stop();
    endtask
`endif

    initial begin
        for (int i = 0; i < 13; i++) begin
            logic [12:0] one;
            one = 13'h0;
            if (codes[i] != 0) one[codes[i]] = 1'b1;
            for (int c = 0; c < (lens[i] + 1) * 4; c++) trace.push_back(one);
            repeat (3) trace.push_back(13'h0);
        end

        test_reset();
        test_single_pass();
        test_repeat();
        test_stop();
        test_start_stop_idle();
        test_start_during_play();
        test_async_reset();
`ifdef MELODY_SNOOZE_EN
        test_snooze();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
